sccb_target: RTL and testbench

SCCB_TARGET -- requirements
Module: sccb_target

---
 rtl/sccb_pkg.sv | 26 ++
 rtl/sccb_sync_edge.sv | 37 +++
 rtl/sccb_target.sv | 157 +++++++++++++++
 tb/tb_sccb_target.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB write target.
// Holds the target FSM state encoding, the default device address and the
// number of sioc edges per phase (8 data bits plus one don't-care bit).
package sccb_pkg;

  // 7-bit write address in [7:1]; bit 0 is the R/W flag and is ignored here.
  localparam logic [7:0] DEV_ID_DEFAULT = 8'h42;

  // Every SCCB phase is 8 bits followed by a don't-care bit.
  localparam int PHASE_BITS = 9;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ID        = 3'd1,
    SUB       = 3'd2,
    DATA      = 3'd3,
    WAIT_STOP = 3'd4,
    IGNORE    = 3'd5
  } state_e;

  // True when a received ID byte addresses this device for a write.
  function automatic logic id_is_write_to(input logic [7:0] rx, input logic [7:0] dev);
    return (rx[7:1] == dev[7:1]) && !rx[0];
  endfunction

endpackage

// File: rtl/sccb_sync_edge.sv
// sccb_sync_edge: multi-flop synchronizer with one-cycle-delayed copy and edge flags.
// Latency: SYNC_STAGES clk from d_i to sync_o; rise_o/fall_o valid in the same cycle as sync_o.
// Backpressure: none, free-running sampler.
// Ports: clk, rst (async, active-high); d_i async input; sync_o synchronized value;
//        prev_o sync_o delayed one clk; rise_o / fall_o single-cycle edge flags.
module sccb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic prev_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to all ones so an idle (pulled-up) bus produces no edges on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign prev_o = prev_q;
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB (3-phase write) target that reports register writes to the core.
// Latency: wr_valid one clk after the synchronized 9th sioc edge of the data phase.
// Backpressure: none; each completed write is a one-clk pulse that the core must take.
// Ports: clk, rst (async, active-high); sioc/siod async bus inputs (siod never driven);
//        busy between start and stop; wr_valid/wr_addr/wr_data write report;
//        err protocol-error pulse; wr_count running count of completed writes.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = DEV_ID_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sioc,
  input  logic        siod,
  output logic        busy,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        err,
  output logic [15:0] wr_count
);

  localparam logic [3:0] LAST_BIT = 4'(PHASE_BITS - 1);

  logic scl, scl_prev, scl_rise, scl_fall;
  logic sda, sda_prev, sda_rise, sda_fall;

  sccb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sioc (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sioc),
    .sync_o (scl),
    .prev_o (scl_prev),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  sccb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_siod (
    .clk    (clk),
    .rst    (rst),
    .d_i    (siod),
    .sync_o (sda),
    .prev_o (sda_prev),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  // The sampled siod level and the sioc falling edge play no part in decoding.
  logic unused_sync;
  assign unused_sync = ^{scl_fall, sda, sda_prev};

  // Requiring sioc high in both samples means an siod change coinciding with an
  // sioc rising edge is treated as a data sample, never as start/stop.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl & scl_prev;
  assign stop_det  = sda_rise & scl & scl_prev;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  sub_q, sub_d;
  logic        wr_valid_q, wr_valid_d;
  logic        err_q, err_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sub_q      <= '0;
      wr_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sub_q      <= sub_d;
      wr_valid_q <= wr_valid_d;
      err_q      <= err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sub_d      = sub_q;
    wr_valid_d = 1'b0;
    err_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q;

    if (stop_det) begin
      // A stop before the data byte is complete aborts a write in progress.
      if (state_q == SUB || state_q == DATA) begin
        err_d = 1'b1;
      end
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (start_det) begin
      // Plain or repeated start: any partially received byte is dropped.
      state_d   = ID;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (scl_rise) begin
      if (state_q == IDLE) begin
        err_d = 1'b1;
      end else if (bit_cnt_q == LAST_BIT) begin
        // 9th edge: the don't-care bit closes the phase without being shifted.
        bit_cnt_d = '0;
        unique case (state_q)
          ID: begin
            state_d = id_is_write_to(shift_q, DEV_ID) ? SUB : IGNORE;
          end
          SUB: begin
            sub_d   = shift_q;
            state_d = DATA;
          end
          DATA: begin
            wr_valid_d = 1'b1;
            wr_addr_d  = sub_q;
            wr_data_d  = shift_q;
            wr_count_d = wr_count_q + 16'd1;
            state_d    = WAIT_STOP;
          end
          WAIT_STOP: begin
            err_d = 1'b1;
          end
          default: ;
        endcase
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {shift_q[6:0], sda};
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err      = err_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: self-checking bench for sccb_target.
// A bus-level master drives SCCB transactions; a transaction-level model predicts
// the reported writes, error pulses and write count for each one.
module tb_sccb_target;

  localparam logic [7:0] DEV = 8'h42;

  logic        clk = 1'b0;
  logic        rst;
  logic        sioc;
  logic        siod;
  logic        busy;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        err;
  logic [15:0] wr_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Observed events, collected by the monitor.
  int          err_cnt = 0;
  int          wr_n    = 0;
  logic [15:0] wr_log [0:255];

  // Model state.
  logic [15:0] exp_count;
  logic [15:0] exp_last;

  // Bit-phase duration range in clk cycles.
  int hold_min = 5;
  int hold_max = 8;

  sccb_target #(.DEV_ID(DEV), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sioc     (sioc),
    .siod     (siod),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .err      (err),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_log[wr_n[7:0]] <= {wr_addr, wr_data};
      wr_n <= wr_n + 1;
    end
    if (err) err_cnt <= err_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1);
  end

  // ---------------- bus master ----------------
  task automatic hold();
    repeat ($urandom_range(hold_min, hold_max)) @(negedge clk);
  endtask

  // Works from idle (both high) and as a repeated start (sioc low).
  task automatic start_cond();
    siod = 1'b1; hold();
    sioc = 1'b1; hold();
    siod = 1'b0; hold();
    sioc = 1'b0; hold();
  endtask

  task automatic stop_cond();
    siod = 1'b0; hold();
    sioc = 1'b1; hold();
    siod = 1'b1; hold();
  endtask

  task automatic send_bit(input logic b);
    siod = b;    hold();
    sioc = 1'b1; hold();
    sioc = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(1'($urandom));
    hold();
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  // Start, n bytes (first is the ID), stop.
  task automatic run_txn(input logic [31:0] bytes, input int n);
    start_cond();
    for (int i = 0; i < n; i++) send_byte(bytes[31-8*i -: 8]);
    stop_cond();
    settle();
  endtask

  // Transaction-level expectation: a write is reported when the ID addresses us
  // for writing and at least three bytes arrive; stopping after only ID or ID+sub
  // is one error; each byte beyond the third is one error.
  function automatic void model_txn(input logic [31:0] bytes, input int n,
                                    output bit wr, output int errs);
    bit ok;
    ok   = (bytes[31:25] == DEV[7:1]) && (bytes[24] == 1'b0);
    wr   = ok && (n >= 3);
    errs = 0;
    if (ok && (n == 1 || n == 2)) errs = 1;
    if (ok && n > 3) errs = n - 3;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; sioc = 1'b1; siod = 1'b1;
    repeat (3) @(negedge clk);
    exp_count = 16'd0;
    exp_last  = 16'd0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%b exp=0", err); end
    tests_run++; if ({wr_addr, wr_data} !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr_data got=%h exp=0000", {wr_addr, wr_data}); end
    tests_run++; if (wr_count !== 16'h0000) begin tests_failed++; $display("FAIL reset_count got=%h exp=0000", wr_count); end
    rst = 1'b0;
    settle();
  endtask

  task automatic test_basic_write();
    int eb, wb;
    eb = err_cnt; wb = wr_n;
    start_cond();
    send_byte(8'h42);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_mid got=%b exp=1", busy); end
    send_byte(8'h12);
    send_byte(8'h80);
    stop_cond();
    settle();
    exp_count++; exp_last = 16'h1280;
    tests_run++; if (wr_n - wb !== 1) begin tests_failed++; $display("FAIL basic_nwrites got=%0d exp=1", wr_n - wb); end
    tests_run++; if (wr_log[wb[7:0]] !== 16'h1280) begin tests_failed++; $display("FAIL basic_logged got=%h exp=1280", wr_log[wb[7:0]]); end
    tests_run++; if (err_cnt - eb !== 0) begin tests_failed++; $display("FAIL basic_err got=%0d exp=0", err_cnt - eb); end
    tests_run++; if ({wr_addr, wr_data} !== exp_last) begin tests_failed++; $display("FAIL basic_held got=%h exp=%h", {wr_addr, wr_data}, exp_last); end
    tests_run++; if (wr_count !== exp_count) begin tests_failed++; $display("FAIL basic_count got=%0d exp=%0d", wr_count, exp_count); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_ignore();
    logic [7:0] ids [2];
    int eb, wb;
    ids[0] = 8'h43; ids[1] = 8'h60;
    for (int k = 0; k < 2; k++) begin
      eb = err_cnt; wb = wr_n;
      start_cond();
      send_byte(ids[k]);
      send_byte(8'($urandom));
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ignore_busy_mid id=%h got=%b exp=1", ids[k], busy); end
      send_byte(8'($urandom));
      stop_cond();
      settle();
      tests_run++; if (wr_n - wb !== 0) begin tests_failed++; $display("FAIL ignore_nwrites id=%h got=%0d exp=0", ids[k], wr_n - wb); end
      tests_run++; if (err_cnt - eb !== 0) begin tests_failed++; $display("FAIL ignore_err id=%h got=%0d exp=0", ids[k], err_cnt - eb); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ignore_busy_end id=%h got=%b exp=0", ids[k], busy); end
    end
  endtask

  task automatic test_short_err();
    int eb, wb;
    eb = err_cnt; wb = wr_n;
    run_txn({8'h42, 8'h11, 16'h0000}, 2);
    tests_run++; if (err_cnt - eb !== 1) begin tests_failed++; $display("FAIL short_err got=%0d exp=1", err_cnt - eb); end
    tests_run++; if (wr_n - wb !== 0) begin tests_failed++; $display("FAIL short_nwrites got=%0d exp=0", wr_n - wb); end
    tests_run++; if ({wr_addr, wr_data} !== exp_last) begin tests_failed++; $display("FAIL short_held got=%h exp=%h", {wr_addr, wr_data}, exp_last); end
    tests_run++; if (wr_count !== exp_count) begin tests_failed++; $display("FAIL short_count got=%0d exp=%0d", wr_count, exp_count); end
  endtask

  task automatic test_repeated_start();
    int eb, wb;
    eb = err_cnt; wb = wr_n;
    start_cond();
    send_byte(8'h42);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    hold();
    start_cond();
    send_byte(8'h42);
    send_byte(8'h3A);
    send_byte(8'h04);
    stop_cond();
    settle();
    exp_count++; exp_last = 16'h3A04;
    tests_run++; if (wr_n - wb !== 1) begin tests_failed++; $display("FAIL rstart_nwrites got=%0d exp=1", wr_n - wb); end
    tests_run++; if (wr_log[wb[7:0]] !== 16'h3A04) begin tests_failed++; $display("FAIL rstart_logged got=%h exp=3a04", wr_log[wb[7:0]]); end
    tests_run++; if (err_cnt - eb !== 0) begin tests_failed++; $display("FAIL rstart_err got=%0d exp=0", err_cnt - eb); end
    tests_run++; if (wr_count !== exp_count) begin tests_failed++; $display("FAIL rstart_count got=%0d exp=%0d", wr_count, exp_count); end
  endtask

  task automatic test_extra_byte();
    int eb, wb;
    eb = err_cnt; wb = wr_n;
    run_txn({8'h42, 8'h55, 8'hAA, 8'h77}, 4);
    exp_count++; exp_last = 16'h55AA;
    tests_run++; if (wr_n - wb !== 1) begin tests_failed++; $display("FAIL extra_nwrites got=%0d exp=1", wr_n - wb); end
    tests_run++; if ({wr_addr, wr_data} !== 16'h55AA) begin tests_failed++; $display("FAIL extra_held got=%h exp=55aa", {wr_addr, wr_data}); end
    tests_run++; if (err_cnt - eb !== 1) begin tests_failed++; $display("FAIL extra_err got=%0d exp=1", err_cnt - eb); end
  endtask

  task automatic test_idle_sioc();
    int eb, wb;
    eb = err_cnt; wb = wr_n;
    for (int i = 0; i < 3; i++) begin
      sioc = 1'b0; hold();
      sioc = 1'b1; hold();
    end
    settle();
    tests_run++; if (err_cnt - eb !== 3) begin tests_failed++; $display("FAIL idle_sioc_err got=%0d exp=3", err_cnt - eb); end
    tests_run++; if (wr_n - wb !== 0) begin tests_failed++; $display("FAIL idle_sioc_nwrites got=%0d exp=0", wr_n - wb); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_sioc_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int eb, wb;
    start_cond();
    send_byte(8'h42);
    send_byte(8'h77);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    hold();
    rst = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy_async got=%b exp=0", busy); end
    exp_count = 16'd0; exp_last = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    eb = err_cnt; wb = wr_n;
    // The master finishes its interrupted phase (5 edges) and its stop adds one
    // more sioc rise; the target is idle for all six.
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    hold();
    stop_cond();
    settle();
    tests_run++; if (err_cnt - eb !== 6) begin tests_failed++; $display("FAIL rstmid_err got=%0d exp=6", err_cnt - eb); end
    tests_run++; if (wr_n - wb !== 0) begin tests_failed++; $display("FAIL rstmid_nwrites got=%0d exp=0", wr_n - wb); end
    tests_run++; if (wr_count !== 16'd0) begin tests_failed++; $display("FAIL rstmid_count0 got=%0d exp=0", wr_count); end
    eb = err_cnt; wb = wr_n;
    run_txn({8'h42, 8'h40, 8'hD0, 8'h00}, 3);
    exp_count++; exp_last = 16'h40D0;
    tests_run++; if (wr_n - wb !== 1) begin tests_failed++; $display("FAIL rstmid_post_nwrites got=%0d exp=1", wr_n - wb); end
    tests_run++; if (wr_log[wb[7:0]] !== 16'h40D0) begin tests_failed++; $display("FAIL rstmid_post_logged got=%h exp=40d0", wr_log[wb[7:0]]); end
    tests_run++; if (wr_count !== 16'd1) begin tests_failed++; $display("FAIL rstmid_post_count got=%0d exp=1", wr_count); end
    tests_run++; if (err_cnt - eb !== 0) begin tests_failed++; $display("FAIL rstmid_post_err got=%0d exp=0", err_cnt - eb); end
  endtask

  task automatic test_random();
    int ntab [8] = '{0, 1, 2, 3, 3, 3, 3, 4};
    for (int k = 0; k < 20; k++) begin
      logic [7:0]  id;
      logic [31:0] bytes;
      int          n, eb, wb, exp_err;
      bit          exp_wr;
      id = DEV;
      if ($urandom_range(0, 3) == 0) id = 8'($urandom);
      if ($urandom_range(0, 7) == 0) id = DEV | 8'h01;
      n = ntab[$urandom_range(0, 7)];
      bytes = {id, 8'($urandom), 8'($urandom), 8'($urandom)};
      model_txn(bytes, n, exp_wr, exp_err);
      eb = err_cnt; wb = wr_n;
      run_txn(bytes, n);
      if (exp_wr) begin exp_count++; exp_last = bytes[23:8]; end
      tests_run++; if (wr_n - wb !== (exp_wr ? 1 : 0)) begin tests_failed++; $display("FAIL rand_nwrites k=%0d bytes=%h n=%0d got=%0d exp=%0d", k, bytes, n, wr_n - wb, exp_wr ? 1 : 0); end
      if (exp_wr) begin
        tests_run++; if (wr_log[wb[7:0]] !== bytes[23:8]) begin tests_failed++; $display("FAIL rand_logged k=%0d got=%h exp=%h", k, wr_log[wb[7:0]], bytes[23:8]); end
      end
      tests_run++; if (err_cnt - eb !== exp_err) begin tests_failed++; $display("FAIL rand_err k=%0d bytes=%h n=%0d got=%0d exp=%0d", k, bytes, n, err_cnt - eb, exp_err); end
      tests_run++; if (wr_count !== exp_count) begin tests_failed++; $display("FAIL rand_count k=%0d got=%0d exp=%0d", k, wr_count, exp_count); end
      tests_run++; if ({wr_addr, wr_data} !== exp_last) begin tests_failed++; $display("FAIL rand_held k=%0d got=%h exp=%h", k, {wr_addr, wr_data}, exp_last); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rand_busy k=%0d got=%b exp=0", k, busy); end
    end
  endtask

  // Camera register table sent back-to-back at the fastest supported timing.
  task automatic test_back_to_back();
    logic [15:0] tbl [8] = '{16'h1280, 16'h1204, 16'h1101, 16'h0C00,
                             16'h3E00, 16'h40D0, 16'h3A04, 16'h8C00};
    int eb, wb, cb;
    hold_min = 4; hold_max = 5;
    eb = err_cnt; wb = wr_n; cb = int'(wr_count);
    for (int i = 0; i < 8; i++) begin
      start_cond();
      send_byte(DEV);
      send_byte(tbl[i][15:8]);
      send_byte(tbl[i][7:0]);
      stop_cond();
    end
    settle();
    exp_count += 16'd8; exp_last = tbl[7];
    tests_run++; if (wr_n - wb !== 8) begin tests_failed++; $display("FAIL b2b_nwrites got=%0d exp=8", wr_n - wb); end
    for (int i = 0; i < 8; i++) begin
      tests_run++; if (wr_log[8'(wb + i)] !== tbl[i]) begin tests_failed++; $display("FAIL b2b_entry i=%0d got=%h exp=%h", i, wr_log[8'(wb + i)], tbl[i]); end
    end
    tests_run++; if (int'(wr_count) - cb !== 8) begin tests_failed++; $display("FAIL b2b_count_delta got=%0d exp=8", int'(wr_count) - cb); end
    tests_run++; if (wr_count !== exp_count) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=%0d", wr_count, exp_count); end
    tests_run++; if (err_cnt - eb !== 0) begin tests_failed++; $display("FAIL b2b_err got=%0d exp=0", err_cnt - eb); end
    hold_min = 5; hold_max = 8;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_ignore();
    test_short_err();
    test_repeated_start();
    test_extra_byte();
    test_idle_sioc();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
